// File: rtl/bus_slot_bridge.sv
// rtl/bus_slot_bridge.sv - CPU bus to NUM_SLOTS peripheral window bridge with busy handshake and halt.
// Optional hung-slot abort is enabled by defining BUS_SLOT_TIMEOUT_EN.
module bus_slot_bridge #(
    parameter int                       NUM_SLOTS    = 4,
    parameter int                       ADDR_W       = 32,
    parameter int                       DATA_W       = 32,
    parameter logic [ADDR_W-1:0]        BASE_ADDR    = 'h9000,
    parameter logic [ADDR_W-1:0]        SLOT_SPAN    = 'h100,
    parameter logic [NUM_SLOTS-1:0]     BUSY_EN_MASK = '0,
    parameter int                       TIMEOUT_CYC  = 256,
    parameter logic [DATA_W-1:0]        ERR_DATA     = 'hDEAD_BEEF
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        req_i,
    input  logic                        we_i,
    input  logic [ADDR_W-1:0]           addr_i,
    input  logic [DATA_W-1:0]           wdata_i,
    output logic [DATA_W-1:0]           rdata_o,
    output logic                        ack_o,
    output logic                        halt_o,
    output logic                        err_o,
    input  logic                        err_clr_i,
    output logic [NUM_SLOTS-1:0]        slot_sel_o,
    output logic                        slot_we_o,
    output logic [ADDR_W-1:0]           slot_addr_o,
    output logic [DATA_W-1:0]           slot_wdata_o,
    input  logic [NUM_SLOTS*DATA_W-1:0] slot_rdata_i,
    input  logic [NUM_SLOTS-1:0]        slot_busy_i
);

    localparam int                IDX_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int                SPAN_LG   = $clog2(SLOT_SPAN);
    localparam logic [ADDR_W-1:0] SPAN_MASK = SLOT_SPAN - ADDR_W'(1);
    localparam logic [ADDR_W:0]   WIN_SIZE  = {1'b0, SLOT_SPAN} * (ADDR_W+1)'(NUM_SLOTS);

    if (NUM_SLOTS < 1 || NUM_SLOTS > 16 || (SLOT_SPAN & SPAN_MASK) != '0 ||
        TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65536) begin : g_param_check
        $error("bus_slot_bridge: illegal parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_we;
    logic [DATA_W-1:0]    r_rdata;
    logic                 r_ack;
    logic                 r_err;
    logic [NUM_SLOTS-1:0] r_slot_sel;
    logic                 r_slot_we;
    logic [ADDR_W-1:0]    r_slot_addr;
    logic [DATA_W-1:0]    r_slot_wdata;
`ifdef BUS_SLOT_TIMEOUT_EN
    logic [15:0]          r_wait_cnt;
`endif

    logic [ADDR_W-1:0]    w_offset;
    logic                 w_hit;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_busy;
    logic [DATA_W-1:0]    w_sel_rdata;

    // Unsigned subtraction wraps below BASE_ADDR, so the lower bound is checked explicitly.
    assign w_offset    = addr_i - BASE_ADDR;
    assign w_hit       = (addr_i >= BASE_ADDR) && ({1'b0, w_offset} < WIN_SIZE);
    assign w_idx       = IDX_W'(w_offset >> SPAN_LG);
    assign w_busy      = BUSY_EN_MASK[r_idx] & slot_busy_i[r_idx];
    assign w_sel_rdata = slot_rdata_i[r_idx*DATA_W +: DATA_W];

    assign halt_o       = (req_i && r_state == S_IDLE) || r_state == S_ISSUE || r_state == S_WAIT;
    assign rdata_o      = r_rdata;
    assign ack_o        = r_ack;
    assign err_o        = r_err;
    assign slot_sel_o   = r_slot_sel;
    assign slot_we_o    = r_slot_we;
    assign slot_addr_o  = r_slot_addr;
    assign slot_wdata_o = r_slot_wdata;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_we         <= 1'b0;
            r_rdata      <= '0;
            r_ack        <= 1'b0;
            r_err        <= 1'b0;
            r_slot_sel   <= '0;
            r_slot_we    <= 1'b0;
            r_slot_addr  <= '0;
            r_slot_wdata <= '0;
`ifdef BUS_SLOT_TIMEOUT_EN
            r_wait_cnt   <= '0;
`endif
        end else begin
            r_ack      <= 1'b0;
            r_slot_sel <= '0;
            r_slot_we  <= 1'b0;
            // Clear first so that an error raised below in the same cycle takes priority.
            if (err_clr_i) begin
                r_err <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (req_i) begin
                        if (w_hit) begin
                            r_idx             <= w_idx;
                            r_we              <= we_i;
                            r_slot_addr       <= addr_i & SPAN_MASK;
                            r_slot_wdata      <= wdata_i;
                            r_slot_sel[w_idx] <= 1'b1;
                            r_slot_we         <= we_i;
                            r_state           <= S_ISSUE;
                        end else begin
                            r_rdata <= ERR_DATA;
                            r_err   <= 1'b1;
                            r_ack   <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_ISSUE: begin
`ifdef BUS_SLOT_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_busy) begin
`ifdef BUS_SLOT_TIMEOUT_EN
                        if (r_wait_cnt == 16'(TIMEOUT_CYC - 1)) begin
                            r_rdata <= ERR_DATA;
                            r_err   <= 1'b1;
                            r_ack   <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + 16'd1;
                        end
`endif
                    end else begin
                        r_rdata <= r_we ? '0 : w_sel_rdata;
                        r_ack   <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_slot_bridge.sv
// tb/tb_bus_slot_bridge.sv - directed table-driven bench for bus_slot_bridge.
module tb_bus_slot_bridge;

    logic         clk = 1'b0;
    logic         reset_i;
    logic         req_i;
    logic         we_i;
    logic [31:0]  addr_i;
    logic [31:0]  wdata_i;
    logic [31:0]  rdata_o;
    logic         ack_o;
    logic         halt_o;
    logic         err_o;
    logic         err_clr_i;
    logic [3:0]   slot_sel_o;
    logic         slot_we_o;
    logic [31:0]  slot_addr_o;
    logic [31:0]  slot_wdata_o;
    logic [127:0] slot_rdata_i;
    logic [3:0]   slot_busy_i;

    always #5 clk = ~clk;

    bus_slot_bridge #(
        .NUM_SLOTS(4), .ADDR_W(32), .DATA_W(32),
        .BASE_ADDR(32'h9000), .SLOT_SPAN(32'h100),
        .BUSY_EN_MASK(4'b0010), .TIMEOUT_CYC(8), .ERR_DATA(32'hDEAD_BEEF)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .req_i(req_i), .we_i(we_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .ack_o(ack_o),
        .halt_o(halt_o), .err_o(err_o), .err_clr_i(err_clr_i),
        .slot_sel_o(slot_sel_o), .slot_we_o(slot_we_o), .slot_addr_o(slot_addr_o),
        .slot_wdata_o(slot_wdata_o), .slot_rdata_i(slot_rdata_i), .slot_busy_i(slot_busy_i)
    );

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  busy;
        int          rel;
        logic [3:0]  exp_sel;
        logic [31:0] exp_addr;
        logic [31:0] exp_rdata;
        int          exp_lat;
        logic        exp_err;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    int          o_lat;
    logic [31:0] o_rdata;
    int          o_sel_cnt;
    logic [3:0]  o_sel;
    logic        o_sel_we;
    logic [31:0] o_sel_addr;
    logic [31:0] o_sel_wdata;
    logic        o_halt_ok;
    logic        o_done_halt;
    logic        o_err;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issues one transaction at a negedge and observes it cycle by cycle until ack_o.
    task automatic run_txn(input vec_t v);
        @(negedge clk);
        req_i = 1'b1; we_i = v.we; addr_i = v.addr; wdata_i = v.wdata; slot_busy_i = v.busy;
        o_lat = 0; o_rdata = 'x; o_sel_cnt = 0; o_sel = '0; o_sel_we = 1'b0;
        o_sel_addr = 'x; o_sel_wdata = 'x; o_halt_ok = 1'b1; o_done_halt = 1'b1; o_err = 1'bx;
        #1;
        if (!halt_o) o_halt_ok = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (slot_sel_o != 4'b0000) begin
                o_sel_cnt++;
                o_sel = slot_sel_o; o_sel_we = slot_we_o;
                o_sel_addr = slot_addr_o; o_sel_wdata = slot_wdata_o;
            end
            if (ack_o) begin
                o_lat = k; o_rdata = rdata_o; o_done_halt = halt_o; o_err = err_o;
                break;
            end
            if (!halt_o) o_halt_ok = 1'b0;
            if (k == v.rel) slot_busy_i = 4'b0000;
        end
        req_i = 1'b0; slot_busy_i = 4'b0000;
        err_clr_i = 1'b1;
        @(negedge clk);
        err_clr_i = 1'b0;
    endtask

    vec_t vecs[$];
    int   acks, first_k, second_k;
    logic [31:0] rd1, rd2;

    initial begin
        reset_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
        err_clr_i = 1'b0; slot_busy_i = '0;
        slot_rdata_i = {32'h3333_3333, 32'h1234_5678, 32'hCAFE_0001, 32'h0000_1111};

        vecs.push_back('{"rd_slot2",      1'b0, 32'h9204, 32'h0,    4'b0000, 0, 4'b0100, 32'h04, 32'h1234_5678, 3, 1'b0});
        vecs.push_back('{"wr_slot0",      1'b1, 32'h9010, 32'hA5A5, 4'b0000, 0, 4'b0001, 32'h10, 32'h0,         3, 1'b0});
        vecs.push_back('{"rd_slot1_busy", 1'b0, 32'h9108, 32'h0,    4'b0010, 7, 4'b0010, 32'h08, 32'hCAFE_0001, 8, 1'b0});
        vecs.push_back('{"rd_slot3_unmsk",1'b0, 32'h9300, 32'h0,    4'b1000, 0, 4'b1000, 32'h00, 32'h3333_3333, 3, 1'b0});
        vecs.push_back('{"rd_slot1_other",1'b0, 32'h9100, 32'h0,    4'b1001, 0, 4'b0010, 32'h00, 32'hCAFE_0001, 3, 1'b0});
        vecs.push_back('{"rd_last_word",  1'b0, 32'h93FC, 32'h0,    4'b0000, 0, 4'b1000, 32'hFC, 32'h3333_3333, 3, 1'b0});
        vecs.push_back('{"miss_above",    1'b0, 32'h9400, 32'h0,    4'b0000, 0, 4'b0000, 32'h00, 32'hDEAD_BEEF, 1, 1'b1});
        vecs.push_back('{"miss_8000",     1'b0, 32'h8000, 32'h0,    4'b0000, 0, 4'b0000, 32'h00, 32'hDEAD_BEEF, 1, 1'b1});
        vecs.push_back('{"miss_below",    1'b1, 32'h8FFC, 32'h77,   4'b0000, 0, 4'b0000, 32'h00, 32'h0DEADBEEF, 1, 1'b1});
`ifdef BUS_SLOT_TIMEOUT_EN
        vecs.push_back('{"timeout_slot1", 1'b0, 32'h9100, 32'h0,    4'b0010, 0, 4'b0010, 32'h00, 32'hDEAD_BEEF, 10, 1'b1});
`endif

        repeat (3) @(negedge clk);
        check("reset_rdata", rdata_o, 32'h0);
        check("reset_ack", {31'h0, ack_o}, 32'h0);
        check("reset_halt", {31'h0, halt_o}, 32'h0);
        check("reset_err", {31'h0, err_o}, 32'h0);
        check("reset_sel", {28'h0, slot_sel_o}, 32'h0);
        reset_i = 1'b0;

        foreach (vecs[i]) begin
            run_txn(vecs[i]);
            check($sformatf("%s_lat", vecs[i].name), o_lat, vecs[i].exp_lat);
            check($sformatf("%s_rdata", vecs[i].name), o_rdata, vecs[i].exp_rdata);
            check($sformatf("%s_err", vecs[i].name), {31'h0, o_err}, {31'h0, vecs[i].exp_err});
            check($sformatf("%s_halt", vecs[i].name), {31'h0, o_halt_ok}, 32'h1);
            check($sformatf("%s_done_halt", vecs[i].name), {31'h0, o_done_halt}, 32'h0);
            if (vecs[i].exp_sel != 4'b0000) begin
                check($sformatf("%s_sel_cnt", vecs[i].name), o_sel_cnt, 1);
                check($sformatf("%s_sel", vecs[i].name), {28'h0, o_sel}, {28'h0, vecs[i].exp_sel});
                check($sformatf("%s_sel_we", vecs[i].name), {31'h0, o_sel_we}, {31'h0, vecs[i].we});
                check($sformatf("%s_sel_addr", vecs[i].name), o_sel_addr, vecs[i].exp_addr);
                check($sformatf("%s_sel_wdata", vecs[i].name), o_sel_wdata, vecs[i].wdata);
            end else begin
                check($sformatf("%s_no_strobe", vecs[i].name), o_sel_cnt, 0);
            end
        end

        // Back-to-back: next request presented in DONE, accepted in the following IDLE cycle.
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h9204;
        acks = 0; first_k = 0; second_k = 0; rd1 = '0; rd2 = '0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (ack_o) begin
                acks++;
                if (acks == 1) begin
                    first_k = k; rd1 = rdata_o; addr_i = 32'h9000;
                end else begin
                    second_k = k; rd2 = rdata_o; req_i = 1'b0;
                end
            end
        end
        check("b2b_ack_count", acks, 2);
        check("b2b_first_lat", first_k, 3);
        check("b2b_second_lat", second_k, 7);
        check("b2b_rd1", rd1, 32'h1234_5678);
        check("b2b_rd2", rd2, 32'h0000_1111);
        check("rdata_hold", rdata_o, 32'h0000_1111);

        // Sticky error: clear and a new miss in the same cycle leaves err_o set.
        @(negedge clk);
        req_i = 1'b1; addr_i = 32'h8000;
        @(negedge clk);
        req_i = 1'b0;
        check("err_first_miss", {31'h0, err_o}, 32'h1);
        @(negedge clk);
        req_i = 1'b1; addr_i = 32'h8004; err_clr_i = 1'b1;
        @(negedge clk);
        req_i = 1'b0; err_clr_i = 1'b0;
        check("err_set_wins", {31'h0, err_o}, 32'h1);
        check("err_set_wins_ack", {31'h0, ack_o}, 32'h1);
        repeat (2) @(negedge clk);
        check("err_sticky", {31'h0, err_o}, 32'h1);
        err_clr_i = 1'b1;
        @(negedge clk);
        err_clr_i = 1'b0;
        check("err_cleared", {31'h0, err_o}, 32'h0);

        // Reset while WAIT is stalled on a busy slot.
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h9100; slot_busy_i = 4'b0010;
        repeat (3) @(negedge clk);
        check("rst_wait_halt", {31'h0, halt_o}, 32'h1);
        reset_i = 1'b1; req_i = 1'b0;
        @(negedge clk);
        reset_i = 1'b0;
        check("rst_halt", {31'h0, halt_o}, 32'h0);
        check("rst_rdata", rdata_o, 32'h0);
        check("rst_sel", {28'h0, slot_sel_o}, 32'h0);
        acks = 0;
        for (int k = 0; k < 10; k++) begin
            if (ack_o) acks++;
            @(negedge clk);
        end
        check("rst_no_ack", acks, 0);
        slot_busy_i = 4'b0000;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
